// File: rtl/rcv_controller.sv
// UART receive-path controller: sequences the bit timer, stop-bit checker and buffer load.
// Optional RECEIVE-state watchdog enabled by defining RCV_WATCHDOG_EN.
module rcv_controller #(
  parameter int unsigned WDOG_CYCLES = 100
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_bit_detected,
  input  logic       packet_done,
  input  logic       framing_error,
  output logic       sbc_clear,
  output logic       sbc_enable,
  output logic       enable_timer,
  output logic       load_buffer,
  output logic       rcv_busy,
  output logic [7:0] err_count,
  output logic       timeout
);

  localparam int unsigned ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  if ((WDOG_CYCLES == 0) || (WDOG_CYCLES > 255)) begin : g_bad_wdog
    $error("rcv_controller: WDOG_CYCLES must be in 1..255");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    RECEIVE   = 3'd2,
    STOP_CHK  = 3'd3,
    FRAME_CHK = 3'd4,
    LOAD      = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ERR_W-1:0] r_err_count;
  logic [ERR_W-1:0] w_err_nxt;
  logic             w_wdog_trip;

`ifdef RCV_WATCHDOG_EN
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(WDOG_CYCLES);

  logic [CNT_W-1:0] r_wdog_cnt;
  logic [CNT_W-1:0] w_wdog_inc;
  logic             r_timeout;

  // Trips in the RECEIVE cycle that brings the count up to the limit
  assign w_wdog_inc  = r_wdog_cnt + CNT_W'(1);
  assign w_wdog_trip = (r_state == RECEIVE) && (w_wdog_inc == WDOG_LIMIT);

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_wdog_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wdog_cnt <= (r_state == RECEIVE) ? w_wdog_inc : '0;
      r_timeout  <= w_wdog_trip && !packet_done;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_wdog_trip = 1'b0;
  assign timeout     = 1'b0;
`endif

  // Next-state and error-count update
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err_count;
    case (r_state)
      IDLE: begin
        if (start_bit_detected) w_state_nxt = CLEAR;
      end
      CLEAR: w_state_nxt = RECEIVE;
      RECEIVE: begin
        if (packet_done)      w_state_nxt = STOP_CHK;
        else if (w_wdog_trip) w_state_nxt = IDLE;
      end
      STOP_CHK: w_state_nxt = FRAME_CHK;
      FRAME_CHK: begin
        if (framing_error) begin
          w_state_nxt = IDLE;
          if (r_err_count != ERR_MAX) w_err_nxt = r_err_count + ERR_W'(1);
        end else begin
          w_state_nxt = LOAD;
        end
      end
      LOAD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs registered from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state      <= IDLE;
      r_err_count  <= '0;
      sbc_clear    <= 1'b0;
      sbc_enable   <= 1'b0;
      enable_timer <= 1'b0;
      load_buffer  <= 1'b0;
      rcv_busy     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_err_count  <= w_err_nxt;
      sbc_clear    <= (w_state_nxt == CLEAR);
      sbc_enable   <= (w_state_nxt == STOP_CHK);
      enable_timer <= (w_state_nxt == RECEIVE);
      load_buffer  <= (w_state_nxt == LOAD);
      rcv_busy     <= (w_state_nxt != IDLE);
    end
  end

  assign err_count = r_err_count;

endmodule

// File: tb/tb_rcv_controller.sv
// Self-checking bench for rcv_controller: frame-level timeline model with randomized frames and noise.
module tb_rcv_controller;

  localparam int WDOG = 100;
`ifdef RCV_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic       clk;
  logic       n_rst;
  logic       start_bit_detected;
  logic       packet_done;
  logic       framing_error;
  logic       sbc_clear;
  logic       sbc_enable;
  logic       enable_timer;
  logic       load_buffer;
  logic       rcv_busy;
  logic [7:0] err_count;
  logic       timeout;

  rcv_controller #(.WDOG_CYCLES(WDOG)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .start_bit_detected (start_bit_detected),
    .packet_done        (packet_done),
    .framing_error      (framing_error),
    .sbc_clear          (sbc_clear),
    .sbc_enable         (sbc_enable),
    .enable_timer       (enable_timer),
    .load_buffer        (load_buffer),
    .rcv_busy           (rcv_busy),
    .err_count          (err_count),
    .timeout            (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_err  = 0;
  bit exp_to   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {sbc_clear, enable_timer, sbc_enable, load_buffer, rcv_busy, timeout}
  function automatic logic [5:0] outs_now();
    return {sbc_clear, enable_timer, sbc_enable, load_buffer, rcv_busy, timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("idle_outs i=%0d", i), 32'(outs_now()), 32'({5'b0, exp_to}));
      check("idle_err", 32'(err_count), 32'(exp_err));
      exp_to             = 1'b0;
      start_bit_detected = 1'b0;
      packet_done        = rnd_bit();
      framing_error      = rnd_bit();
      tick();
    end
  endtask

  // One frame from the IDLE cycle that sees the start bit. w = RECEIVE cycle (1-based) carrying
  // packet_done; mode 0 quiet, 1 random noise, 2 start held high; rst_at = cycle to pulse reset.
  task automatic run_frame(input int w, input bit fe, input int mode, input int rst_at);
    bit abort;
    int rx;
    int len;
    logic [5:0] e;
    abort = WD_EN && (w > WDOG);
    rx    = abort ? WDOG : w;
    len   = abort ? (2 + rx) : (fe ? (4 + rx) : (5 + rx));
    for (int t = 0; t < len; t++) begin
      if (t == 0)            e = {5'b0, exp_to};
      else if (t == 1)       e = 6'b100010;
      else if (t <= 1 + rx)  e = 6'b010010;
      else if (t == 2 + rx)  e = 6'b001010;
      else if (t == 3 + rx)  e = 6'b000010;
      else                   e = 6'b000110;
      check($sformatf("outs t=%0d w=%0d fe=%0d", t, w, fe), 32'(outs_now()), 32'(e));
      check($sformatf("err t=%0d", t), 32'(err_count), 32'(exp_err));
      exp_to = 1'b0;
      if (t == 0) start_bit_detected = 1'b1;
      else        start_bit_detected = (mode == 2) ? 1'b1 : ((mode == 1) ? rnd_bit() : 1'b0);
      if (!abort && t == 1 + rx)     packet_done = 1'b1;
      else if (t >= 2 && t <= 1 + rx) packet_done = 1'b0;
      else                           packet_done = (mode == 1) ? rnd_bit() : 1'b0;
      if (!abort && t == 3 + rx) framing_error = fe;
      else                       framing_error = (mode == 1) ? rnd_bit() : 1'b0;
      if (t == rst_at) begin
        n_rst = 1'b1;
        tick();
        n_rst   = 1'b0;
        exp_err = 0;
        exp_to  = 1'b0;
        return;
      end
      tick();
      if (!abort && fe && t == 3 + rx && exp_err < 255) exp_err++;
    end
    exp_to = abort;
  endtask

  initial begin
    n_rst              = 1'b1;
    start_bit_detected = 1'b1;
    packet_done        = 1'b1;
    framing_error      = 1'b1;
    repeat (3) tick();
    check("reset_outs", 32'(outs_now()), 32'd0);
    check("reset_err", 32'(err_count), 32'd0);
    n_rst = 1'b0;
    idle_cycles(3);

    // Good frame: packet_done at cycle 92, load at 95
    run_frame(91, 1'b0, 0, -1);
    idle_cycles(2);
    // Bad stop bit
    run_frame(91, 1'b1, 0, -1);
    idle_cycles(1);
    check("bad_frame_err", 32'(err_count), 32'd1);
    // Minimum latency frame
    run_frame(1, 1'b0, 0, -1);
    idle_cycles(1);

    // Randomized frames with noise on ignored inputs
    for (int i = 0; i < 30; i++) begin
      run_frame(int'($urandom_range(1, 140)), rnd_bit(), 1, -1);
      idle_cycles(int'($urandom_range(0, 3)));
    end

    // Watchdog expiry, then packet_done exactly on the limit cycle
    run_frame(WDOG + 5, 1'b0, 0, -1);
    idle_cycles(2);
    run_frame(WDOG, 1'b0, 0, -1);
    idle_cycles(2);

    // Start held high: back-to-back frames with a single IDLE cycle between
    for (int i = 0; i < 3; i++) run_frame(90, 1'b0, 2, -1);
    idle_cycles(2);

    // Mid-frame reset at RECEIVE cycle 40
    run_frame(91, 1'b0, 0, 41);
    check("midrst_outs", 32'(outs_now()), 32'd0);
    check("midrst_err", 32'(err_count), 32'd0);
    idle_cycles(3);

    // Saturation over 256 bad frames
    for (int i = 1; i <= 256; i++) begin
      run_frame(int'($urandom_range(1, 4)), 1'b1, 1, -1);
      if (i == 255 || i == 256) begin
        idle_cycles(1);
        check($sformatf("sat_err frame=%0d", i), 32'(err_count), 32'd255);
      end
    end
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rcv_controller.md
RCV_CONTROLLER -- requirements
Module: rcv_controller

Interface
REQ-001 Parameter WDOG_CYCLES, default 100, is the RECEIVE-state watchdog limit in clock cycles; legal range 1..255.
REQ-002 clk  input  1  rising-edge system clock; all state changes on the rising edge.
REQ-003 n_rst  input  1  reset, synchronous, active-high (1 = reset); sampled on the rising clk edge.
REQ-004 start_bit_detected  input  1  line falling edge seen by the edge detector; level, may stay high several cycles.
REQ-005 packet_done  input  1  one-cycle rollover pulse from the bit timer at the end of the frame.
REQ-006 framing_error  input  1  stop-bit checker result, valid in the FRAME_CHK cycle.
REQ-007 sbc_clear  output  1  clears the stop-bit checker.
REQ-008 sbc_enable  output  1  stop-bit checker sample strobe.
REQ-009 enable_timer  output  1  count enable to the bit timer.
REQ-010 load_buffer  output  1  loads the shift-register contents into the receive buffer.
REQ-011 rcv_busy  output  1  high in every state except IDLE.
REQ-012 err_count  output  8  saturating count of framing errors since reset.
REQ-013 timeout  output  1  one-cycle watchdog abort pulse.

Function
REQ-014 States are IDLE, CLEAR, RECEIVE, STOP_CHK, FRAME_CHK and LOAD, held in one state register.
REQ-015 IDLE -> CLEAR when start_bit_detected=1; otherwise remain in IDLE.
REQ-016 CLEAR -> RECEIVE unconditionally after one cycle.
REQ-017 RECEIVE -> STOP_CHK on the cycle packet_done=1; otherwise remain in RECEIVE, subject to REQ-028.
REQ-018 STOP_CHK -> FRAME_CHK unconditionally.
REQ-019 FRAME_CHK -> IDLE when framing_error=1; FRAME_CHK -> LOAD when framing_error=0.
REQ-020 LOAD -> IDLE unconditionally.
REQ-021 Outputs are Moore outputs decoded from the state register only:
- sbc_clear=1 only in CLEAR
- enable_timer=1 only in RECEIVE
- sbc_enable=1 only in STOP_CHK
- load_buffer=1 only in LOAD
REQ-022 start_bit_detected is ignored in every state except IDLE; a level still high on return to IDLE starts a new frame.
REQ-023 packet_done is ignored in every state except RECEIVE.
REQ-024 err_count increments by 1 in the FRAME_CHK cycle when framing_error=1 and saturates at 255 without wrapping.
REQ-025 Minimum frame latency is 5 cycles from the IDLE start_bit_detected cycle to load_buffer=1, plus the time spent waiting for packet_done.

Reset
REQ-026 n_rst=1 forces IDLE on the next edge, from any state; it overrides every other input.
REQ-027 During and after reset, all 1-bit outputs are 0, err_count=0 and the watchdog count is 0; a frame in flight is discarded with no load_buffer pulse.

Configuration
REQ-028 With RCV_WATCHDOG_EN defined:
- an 8-bit counter clears on entry to RECEIVE and increments each RECEIVE cycle.
- If it reaches WDOG_CYCLES with packet_done=0, the state goes to IDLE and timeout pulses for exactly one cycle, registered and coincident with the IDLE cycle.
- packet_done=1 in that same cycle wins: the state goes to STOP_CHK and timeout stays 0.
REQ-029 Without RCV_WATCHDOG_EN, no watchdog counter exists, timeout is tied to 0, and RECEIVE waits indefinitely for packet_done.

Verification
REQ-030 Good frame: start_bit_detected pulse at cycle 0, packet_done at cycle 92, framing_error=0 -> sbc_clear at cycle 1, enable_timer over cycles 2-92, sbc_enable at cycle 93, load_buffer at cycle 95, err_count stays 0.
REQ-031 Bad stop bit: same stimulus with framing_error=1 in FRAME_CHK -> no load_buffer, return to IDLE, err_count 0->1.
REQ-032 Saturation: 256 consecutive bad frames -> err_count reads 255 after the 255th frame and after the 256th.
REQ-033 Mid-frame reset: n_rst=1 for one cycle at RECEIVE cycle 40 -> IDLE on the next edge, all outputs 0, no load_buffer, err_count=0.
REQ-034 Watchdog (macro on, WDOG_CYCLES=100): start with no packet_done -> enable_timer for 100 cycles, then IDLE with timeout=1 for one cycle; repeating the run with packet_done on cycle 100 -> STOP_CHK and timeout=0.
REQ-035 Held start: start_bit_detected held high for 200 cycles with packet_done every 91 cycles -> back-to-back frames, rcv_busy low for exactly one IDLE cycle between frames.
